clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the waveform of a slow, free-running square signal, such as the output of the team's clock divider, in units of the fast system clock. It reports the full period (rising edge to rising edge) and the high time. It flags a timeout when the signal stops toggling. It sits on the consumer side of the divided clock and gives the light-stand FSM and self-test logic a checked view of the tick rate.

## Interface
- CNT_W, 16: width of the internal counter and of the period/high outputs.
- TIMEOUT, 1000: number of i_clk cycles without an expected edge that declares the input dead. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

- i_clk  input  1  system clock; the only clock in the block.
- i_reset  input  1  asynchronous, active-high reset.
- i_sig  input  1  signal under measurement; asynchronous to i_clk.
- o_period  output  CNT_W  last measured period in i_clk cycles; holds until the next measurement.
- o_high  output  CNT_W  last measured high time in i_clk cycles; updates together with o_period.
- o_valid  output  1  one-cycle pulse when o_period and o_high update.
- o_timeout  output  1  level; set on timeout, cleared on the next o_valid.

## Operation
- Input conditioning:
  - i_sig passes through a 2-flop synchronizer (s1, s2), then a registered copy s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Counter cnt (CNT_W bits):
  - cleared on every rise;
  - otherwise increments by 1 each cycle in MEAS_HIGH and MEAS_LOW;
  - held at 0 in IDLE.
- States:
  - IDLE: wait for rise → MEAS_HIGH, cnt ← 0. Fall is ignored.
  - MEAS_HIGH:
    - on fall: h_cnt ← cnt + 1, go to MEAS_LOW;
    - on a cycle with no fall and cnt == TIMEOUT − 1: go to IDLE, o_timeout ← 1.
  - MEAS_LOW:
    - on rise: o_period ← cnt + 1, o_high ← h_cnt, o_valid ← 1, o_timeout ← 0, cnt ← 0, stay measuring in MEAS_HIGH;
    - on a cycle with no rise and cnt == TIMEOUT − 1: go to IDLE, o_timeout ← 1.
- Arithmetic:
  - period P = number of i_clk cycles between consecutive detected rises; o_period = P.
  - high time H = number of cycles from a detected rise to the next detected fall; o_high = H.
  - cnt never exceeds TIMEOUT − 1, so cnt + 1 cannot overflow CNT_W.
- Boundaries:
  - First rise after reset or timeout produces no o_valid. A full period must elapse first.
  - An edge arriving on the same cycle that cnt reaches TIMEOUT − 1: the edge wins. Measurement of TIMEOUT is valid; TIMEOUT + 1 is not.
  - On timeout, o_period and o_high keep their last values. o_timeout stays 1 until a new full period is measured.
  - Pulses shorter than one i_clk period may be missed. Measured values then reflect the synchronized signal, not the raw one. This is accepted, not an error.
- Reset (asynchronous, any time): state IDLE; s1, s2, s3, cnt, h_cnt, o_period, o_high, o_valid, o_timeout all 0.
  - A reset mid-measurement discards the partial count.
  - If i_sig is high when reset releases, no rise is seen until i_sig goes low and high again.

## Timing
- Latency: i_sig first sampled high at i_clk edge k → s2 high after edge k+1 → rise is active in cycle k+2 → registered outputs and o_valid appear after edge k+2.
  - Total: 3 i_clk edges from sampling to o_valid.
- o_valid is high for exactly one cycle per measured period. Back-to-back periods give pulses P cycles apart.
- o_timeout rises 1 cycle after the cycle in which cnt == TIMEOUT − 1 without the expected edge.
- All outputs are registered; there are no combinational paths from i_sig.

## Test plan
- Divided-clock input (i_sig toggles every 50 i_clk cycles, square wave with P = 100):
  - first o_valid on the second rising edge, 3 edges after sampling;
  - o_period = 100, o_high = 50;
  - o_valid repeats every 100 cycles; o_timeout = 0 throughout.
- Asymmetric input (30 cycles high / 70 low): o_period = 100, o_high = 30 on every o_valid.
- Stall (after valid measurements, hold i_sig low; TIMEOUT = 1000):
  - o_timeout = 1 about 1000 cycles after the last rise;
  - o_period and o_high unchanged.
  - Then resume toggling: no o_valid on the first rise; o_valid with o_timeout → 0 one period later.
- Limit:
  - TIMEOUT = 1000, period 1000 (500/500): valid, o_period = 1000.
  - Period 1001 with a 1000-cycle low phase: o_timeout = 1, no o_valid.
- Reset mid-operation:
  - assert i_reset 40 cycles into MEAS_LOW: all outputs 0 immediately, state IDLE;
  - after release, two rises are required before o_valid, which carries correct values.

Source files
------------

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - period and high-time meter for a slow square signal
//
// Measures a slow free-running square signal in i_clk cycles. A measurement
// starts on a synchronized rising edge and completes on the next one. It
// reports the full period and the high time. A timeout is flagged when no
// expected edge arrives within TIMEOUT cycles.
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset
//   i_sig      signal under measurement, asynchronous to i_clk
//   o_period   last measured period in i_clk cycles
//   o_high     last measured high time in i_clk cycles
//   o_valid    one-cycle pulse when o_period/o_high update
//   o_timeout  level, set on timeout, cleared on the next o_valid

module clock_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] h_cnt, h_cnt_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, timeout_n;

  // s3 is a delayed copy of the synchronized signal, used only for edge detection
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      h_cnt     <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      s1        <= i_sig;
      s2        <= s1;
      s3        <= s2;
      state     <= state_n;
      cnt       <= cnt_n;
      h_cnt     <= h_cnt_n;
      o_period  <= period_n;
      o_high    <= high_n;
      o_valid   <= valid_n;
      o_timeout <= timeout_n;
    end
  end

  // cnt holds (cycles since the last rise) - 1, so the edge-cycle value is cnt + 1.
  // An edge seen in the same cycle as cnt == CNT_LAST is taken before the timeout.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    h_cnt_n   = h_cnt;
    period_n  = o_period;
    high_n    = o_high;
    valid_n   = 1'b0;
    timeout_n = o_timeout;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          state_n = MEAS_HIGH;
        end
      end

      MEAS_HIGH: begin
        cnt_n = cnt + CNT_ONE;
        if (fall) begin
          h_cnt_n = cnt + CNT_ONE;
          state_n = MEAS_LOW;
        end else if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end

      MEAS_LOW: begin
        cnt_n = cnt + CNT_ONE;
        if (rise) begin
          period_n  = cnt + CNT_ONE;
          high_n    = h_cnt;
          valid_n   = 1'b1;
          timeout_n = 1'b0;
          cnt_n     = '0;
          state_n   = MEAS_HIGH;
        end else if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - scoreboard bench for clock_period_meter

module tb_clock_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig = 1'b0;
  logic [CNT_W-1:0] period, high;
  logic             valid, timeout;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_sig    (sig),
    .o_period (period),
    .o_high   (high),
    .o_valid  (valid),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: works on the times at which the bench changes i_sig.
  // A period is reported when two rises are at most TIMEOUT cycles apart
  // and the meter was armed by an earlier rise; otherwise a timeout occurred.
  typedef struct {
    int p;
    int h;
    int t;
  } exp_t;

  exp_t q[$];
  bit   armed     = 0;
  int   last_rise = 0;
  int   last_h    = 0;
  int   last_p_out = 0;
  int   last_h_out = 0;
  bit   exp_tmo   = 0;
  int   n_tmo_exp = 0;
  int   n_tmo_seen = 0;

  task automatic model_timeout();
    if (!exp_tmo) n_tmo_exp++;
    exp_tmo = 1;
    armed   = 0;
  endtask

  task automatic model_rise(input int t);
    exp_t e;
    if (armed && (t - last_rise) <= TIMEOUT) begin
      e.p = t - last_rise;
      e.h = last_h;
      e.t = t + LAT;
      q.push_back(e);
      last_p_out = e.p;
      last_h_out = e.h;
      exp_tmo = 0;
    end else if (armed) begin
      model_timeout();
    end
    armed     = 1;
    last_rise = t;
  endtask

  task automatic model_fall(input int t);
    if (armed) last_h = t - last_rise;
  endtask

  task automatic model_idle(input int t);
    if (armed && (t - last_rise) > TIMEOUT + LAT) model_timeout();
  endtask

  task automatic model_reset();
    armed   = 0;
    exp_tmo = 0;
  endtask

  // Level changes happen 1 time unit after a posedge; cyc is settled then.
  task automatic drive(input logic level, input int n);
    if (level != sig) begin
      if (level) model_rise(cyc);
      else model_fall(cyc);
    end
    sig = level;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every o_valid with the head of the scoreboard
  logic tmo_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      tmo_prev = 1'b0;
    end else begin
      if (timeout && !tmo_prev) n_tmo_seen++;
      tmo_prev = timeout;
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got period %0d high %0d at cycle %0d, expected none",
                   period, high, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("period", int'(period), e.p);
          check("high", int'(high), e.h);
          check("valid_cycle", cyc, e.t);
          check("timeout_on_valid", int'(timeout), 0);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high"}, int'(high), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  task automatic square(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  initial begin
    sig = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    model_reset();
    drive(1'b0, 5);

    // Divided clock, 50/50
    square(50, 50, 6);
    // Asymmetric, 30/70
    square(30, 70, 5);

    // Stall low well beyond TIMEOUT
    drive(1'b0, 1200);
    model_idle(cyc);
    check("stall_timeout", int'(timeout), int'(exp_tmo));
    check("stall_period_held", int'(period), last_p_out);
    check("stall_high_held", int'(high), last_h_out);

    // Resume: first rise re-arms only
    square(50, 50, 3);

    // Limit: period of exactly TIMEOUT is valid
    square(500, 500, 3);
    // Period TIMEOUT+1 with TIMEOUT-cycle low phase times out
    square(1, 1000, 2);
    square(40, 60, 2);

    // Randomized segments, occasionally long enough to hit the timeout window
    for (int i = 0; i < 150; i++) begin
      int h, l;
      h = $urandom_range(1, 60);
      l = $urandom_range(1, 60);
      if ($urandom_range(0, 15) == 0) l = $urandom_range(TIMEOUT - 60, TIMEOUT + 40);
      if ($urandom_range(0, 31) == 0) h = $urandom_range(TIMEOUT - 20, TIMEOUT + 20);
      drive(1'b1, h);
      drive(1'b0, l);
    end

    // Reset 40 cycles into the low phase
    square(50, 50, 2);
    drive(1'b1, 50);
    drive(1'b0, 40);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 5);
    square(50, 50, 4);

    drive(1'b0, 20);
    check("queue_drained", q.size(), 0);
    check("timeout_events", n_tmo_seen, n_tmo_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
